// File: rtl/pkt_h.sv
// rtl/pkt_h.sv - shared packet types and default sizing for the scheduler drain path
package pkt_h;

  localparam int PKT_DWIDTH    = 32;
  localparam int DRAIN_DEPTH   = 8;
  localparam int DRAIN_MAX_OUT = 4;

  typedef logic [PKT_DWIDTH-1:0] pkt_data_t;

endpackage

// File: rtl/pkt_sync_fifo.sv
// rtl/pkt_sync_fifo.sv - registered synchronous FIFO with occupancy count
module pkt_sync_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DWIDTH-1:0]      wdata,
  input  logic                   pop,
  output logic [DWIDTH-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // A push into a full FIFO is accepted when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  // Storage is not reset, so the head is masked to zero while empty.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/pkt_deq_drain.sv
// rtl/pkt_deq_drain.sv - credit-limited dequeue drainer feeding a local egress FIFO
module pkt_deq_drain
  import pkt_h::*;
#(
  parameter int DWIDTH  = PKT_DWIDTH,
  parameter int DEPTH   = DRAIN_DEPTH,
  parameter int MAX_OUT = DRAIN_MAX_OUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         sched_ready,
  output logic                         deq_en,
  input  logic                         sched_valid,
  input  logic [DWIDTH-1:0]            sched_data,
  output logic                         eg_valid,
  input  logic                         eg_ready,
  output logic [DWIDTH-1:0]            eg_data,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic [31:0]                  pkt_count,
  output logic [15:0]                  drop_count,
  output logic                         unexp_err
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [31:0]   pkt_count_q, pkt_count_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          unexp_err_q, unexp_err_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [CW:0]   committed;
  logic          issue, pop, rsp_ok;

  // Buffered words plus in-flight requests must fit, so every response has a slot.
  always_comb begin
    committed     = {1'b0, fifo_count} + (CW + 1)'(outstanding_q);
    issue         = enable && sched_ready && (outstanding_q < MAX_OUT_W) && (committed < DEPTH_W);
    deq_en        = issue && rst_n;
    pop           = !fifo_empty && eg_ready;
    rsp_ok        = sched_valid && (outstanding_q != '0);
    outstanding_d = outstanding_q + OW'(issue) - OW'(rsp_ok);
    pkt_count_d   = pkt_count_q + 32'(pop);
    drop_count_d  = drop_count_q;
    if (sched_valid && fifo_full && !pop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
    unexp_err_d   = unexp_err_q || (sched_valid && (outstanding_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      pkt_count_q   <= '0;
      drop_count_q  <= '0;
      unexp_err_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      pkt_count_q   <= pkt_count_d;
      drop_count_q  <= drop_count_d;
      unexp_err_q   <= unexp_err_d;
    end
  end

  pkt_sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sched_valid),
    .wdata (sched_data),
    .pop   (pop),
    .rdata (eg_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign eg_valid    = !fifo_empty;
  assign outstanding = outstanding_q;
  assign pkt_count   = pkt_count_q;
  assign drop_count  = drop_count_q;
  assign unexp_err   = unexp_err_q;

endmodule

// File: tb/tb_pkt_deq_drain.sv
// tb/tb_pkt_deq_drain.sv - directed self-checking bench for pkt_deq_drain
`timescale 1ns/1ps
module tb_pkt_deq_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sched_ready;
  logic        deq_en;
  logic        sched_valid;
  logic [31:0] sched_data;
  logic        eg_valid;
  logic        eg_ready;
  logic [31:0] eg_data;
  logic [2:0]  outstanding;
  logic [31:0] pkt_count;
  logic [15:0] drop_count;
  logic        unexp_err;

  always #5 clk = ~clk;

  pkt_deq_drain #(
    .DWIDTH  (32),
    .DEPTH   (8),
    .MAX_OUT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sched_ready (sched_ready),
    .deq_en      (deq_en),
    .sched_valid (sched_valid),
    .sched_data  (sched_data),
    .eg_valid    (eg_valid),
    .eg_ready    (eg_ready),
    .eg_data     (eg_data),
    .outstanding (outstanding),
    .pkt_count   (pkt_count),
    .drop_count  (drop_count),
    .unexp_err   (unexp_err)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          mode;       // 0 manual, 1 responder with latency lat, 2 silent
  int          lat;
  logic [3:0]  pipe;
  logic        last_deq;
  logic        chk_hi;
  int          n_issued, n_pop, n_lowdeq, base;
  logic [31:0] rsp_data, exp_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; samples the cycle, crosses one rising edge, drives the next cycle.
  task automatic tick();
    #2;
    last_deq = deq_en;
    if (deq_en) n_issued++;
    if (chk_hi && !deq_en) n_lowdeq++;
    if (eg_valid && eg_ready) begin
      check("eg_data_order", eg_data, exp_next);
      exp_next++;
      n_pop++;
    end
    @(posedge clk);
    #1;
    pipe = {pipe[2:0], last_deq};
    if (mode == 1) begin
      sched_valid = pipe[lat-1];
      if (pipe[lat-1]) begin
        sched_data = rsp_data;
        rsp_data++;
      end
    end else if (mode == 2) begin
      sched_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic quiet_reset();
    rst_n = 1'b0;
    sched_valid = 1'b0;
    pipe = '0;
    last_deq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; sched_ready = 1'b1; sched_valid = 1'b0;
    sched_data = '0; eg_ready = 1'b1;
    mode = 0; lat = 2; pipe = '0; last_deq = 1'b0; chk_hi = 1'b0;
    n_issued = 0; n_pop = 0; n_lowdeq = 0; base = 0;
    rsp_data = 32'h114; exp_next = 32'h114;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_deq_en", deq_en, 0);
    check("rst_eg_valid", eg_valid, 0);
    check("rst_eg_data", eg_data, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_fifo_count", dut.fifo_count, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_unexp_err", unexp_err, 0);
    rst_n = 1'b1;

    // Streaming with a two-cycle scheduler
    mode = 1; lat = 2; chk_hi = 1'b1;
    for (int i = 0; i < 200 && n_pop < 64; i++) tick();
    chk_hi = 1'b0;
    check("t1_pops", n_pop, 64);
    check("t1_pkt_count", pkt_count, 64);
    check("t1_deq_low_cycles", n_lowdeq, 0);
    check("t1_outstanding", outstanding, 2);
    enable = 1'b0;
    for (int i = 0; i < 50 && (outstanding != 0 || eg_valid || pipe != 0); i++) tick();
    check("t1_drain_out", outstanding, 0);
    check("t1_drain_valid", eg_valid, 0);
    check("t1_unexp", unexp_err, 0);

    // Back-pressure with a one-cycle scheduler
    lat = 1; eg_ready = 1'b0; enable = 1'b1; n_issued = 0;
    repeat (20) tick();
    check("t2_issued", n_issued, 8);
    check("t2_deq_held", deq_en, 0);
    check("t2_fifo_count", dut.fifo_count, 8);
    check("t2_outstanding", outstanding, 0);
    check("t2_drop", drop_count, 0);
    check("t2_head", eg_data, exp_next);
    eg_ready = 1'b1; n_issued = 0; base = n_pop;
    repeat (30) tick();
    check("t2_drained8", 32'(n_pop - base >= 8), 1);
    check("t2_resumed", 32'(n_issued > 0), 1);
    enable = 1'b0;
    for (int i = 0; i < 50 && (outstanding != 0 || eg_valid || pipe != 0); i++) tick();
    check("t2_unexp", unexp_err, 0);

    // Silent scheduler
    mode = 2; enable = 1'b1; n_issued = 0;
    repeat (10) tick();
    check("t3_issued", n_issued, 4);
    check("t3_outstanding", outstanding, 4);
    check("t3_eg_valid", eg_valid, 0);
    check("t3_deq_held", deq_en, 0);
    quiet_reset();

    // Unexpected responses, overflow drops, full push with pop
    mode = 0; enable = 1'b0; eg_ready = 1'b0;
    sched_valid = 1'b1; sched_data = 32'hA5A5_0001;
    tick();
    sched_valid = 1'b0;
    check("t4_unexp", unexp_err, 1);
    check("t4_eg_valid", eg_valid, 1);
    check("t4_eg_data", eg_data, 32'hA5A5_0001);
    check("t4_outstanding", outstanding, 0);
    tick();
    check("t4_unexp_sticky", unexp_err, 1);
    for (int i = 2; i <= 8; i++) begin
      sched_valid = 1'b1; sched_data = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    check("t4_full", dut.fifo_count, 8);
    for (int i = 1; i <= 2; i++) begin
      sched_data = 32'hA5A5_0100 + 32'(i);
      tick();
      check("t4_drop", drop_count, 32'(i));
    end
    check("t4_head_stable", eg_data, 32'hA5A5_0001);
    exp_next = 32'hA5A5_0001; eg_ready = 1'b1; sched_data = 32'hA5A5_0009;
    tick();
    sched_valid = 1'b0;
    check("t4_fullpop_drop", drop_count, 2);
    check("t4_fullpop_count", dut.fifo_count, 8);
    for (int i = 0; i < 20 && eg_valid; i++) tick();
    check("t4_drained_to", exp_next, 32'hA5A5_000A);
    check("t4_pkt_count", pkt_count, 9);

    // Reset mid-stream with three outstanding and five buffered
    eg_ready = 1'b0; enable = 1'b1; sched_ready = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) begin
      sched_valid = 1'b1; sched_data = 32'h200 + 32'(j);
      tick();
    end
    sched_valid = 1'b0;
    repeat (2) tick();
    sched_ready = 1'b0;
    check("t5_outstanding", outstanding, 3);
    check("t5_fifo_count", dut.fifo_count, 5);
    check("t5_head", eg_data, 32'h200);
    sched_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_deq_en", deq_en, 0);
    check("t5_rst_eg_valid", eg_valid, 0);
    check("t5_rst_eg_data", eg_data, 0);
    check("t5_rst_outstanding", outstanding, 0);
    check("t5_rst_fifo_count", dut.fifo_count, 0);
    check("t5_rst_pkt_count", pkt_count, 0);
    check("t5_rst_drop_count", drop_count, 0);
    check("t5_rst_unexp", unexp_err, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0;
    sched_valid = 1'b1; sched_data = 32'h300;
    tick();
    sched_valid = 1'b0;
    check("t5_late_unexp", unexp_err, 1);
    check("t5_late_data", eg_data, 32'h300);
    check("t5_late_out", outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
